// File: rtl/mult_pkg.sv
// Shared types and sizing helpers for the shift-and-add multiplier controller.
package mult_pkg;

    localparam int unsigned DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Step counter must hold WIDTH-1 without wrapping.
    function automatic int unsigned cnt_width(input int unsigned width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/full_adder.sv
// One-bit full adder cell used to build the ripple-carry chain.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic c_in,
    output logic s,
    output logic c_out
);

    assign s     = a ^ b ^ c_in;
    assign c_out = (a & b) | (c_in & (a ^ b));

endmodule

// File: rtl/rca_adder.sv
// WIDTH-bit ripple-carry adder formed from a chain of full_adder cells.
module rca_adder #(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic [WIDTH-1:0] s,
    output logic             c_out
);

    logic [WIDTH:0] carry;

    assign carry[0] = c_in;
    assign c_out    = carry[WIDTH];

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        full_adder u_fa (
            .a     (a[i]),
            .b     (b[i]),
            .c_in  (carry[i]),
            .s     (s[i]),
            .c_out (carry[i+1])
        );
    end

endmodule

// File: rtl/shift_add_mult_ctrl.sv
// Sequential unsigned multiplier: one shared adder, one partial-product step per cycle,
// with start/busy/done sequencing and a held product register.
module shift_add_mult_ctrl
    import mult_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int unsigned CW = cnt_width(WIDTH);

    state_t           state;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] mq;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] addend;
    logic [WIDTH-1:0] sum;
    logic             c;
    logic             last_step;

    assign addend    = mq[0] ? mcand : '0;
    assign last_step = (cnt == CW'(WIDTH - 1));

    rca_adder #(
        .WIDTH (WIDTH)
    ) u_adder (
        .a     (acc),
        .b     (addend),
        .c_in  (1'b0),
        .s     (sum),
        .c_out (c)
    );

    // {c, sum, mq} shifted right by one: carry lands in the acc MSB, sum LSB enters mq.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            product <= '0;
            mcand   <= '0;
            acc     <= '0;
            mq      <= '0;
            cnt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        mcand <= a;
                        acc   <= '0;
                        mq    <= b;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    acc <= {c, sum[WIDTH-1:1]};
                    mq  <= {sum[0], mq[WIDTH-1:1]};
                    cnt <= cnt + CW'(1);
                    if (last_step) begin
                        product <= {c, sum, mq[WIDTH-1:1]};
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_add_mult_ctrl.sv
// Self-checking bench for shift_add_mult_ctrl: directed cases plus random operands
// checked against plain multiplication.
module tb_shift_add_mult_ctrl;

    localparam int unsigned W = 4;

    logic           clk;
    logic           rst_n;
    logic           start;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           busy;
    logic           done;
    logic [2*W-1:0] product;

    int checks   = 0;
    int failures = 0;
    int done_cnt = 0;

    shift_add_mult_ctrl #(
        .WIDTH (W)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (done === 1'b1) done_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Launch one multiply from IDLE and check the full busy/done/product timeline.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input string tag);
        int unsigned expv;
        expv  = int'(ta) * int'(tb_v);
        a     = ta;
        b     = tb_v;
        start = 1'b1;
        tick();
        start = 1'b0;
        a     = W'($urandom);
        b     = W'($urandom);
        for (int k = 0; k < int'(W); k++) begin
            check({tag, "_busy"}, 32'(busy), 32'd1);
            check({tag, "_nodone"}, 32'(done), 32'd0);
            tick();
        end
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_busy_low"}, 32'(busy), 32'd0);
        check({tag, "_product"}, 32'(product), expv);
        tick();
        check({tag, "_done_pulse"}, 32'(done), 32'd0);
        check({tag, "_hold"}, 32'(product), expv);
    endtask

    initial begin
        int dc0;
        int seen;
        int last_cyc;
        logic [W-1:0] pa [3];
        logic [W-1:0] pb [3];
        int unsigned  pe [3];

        rst_n = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;

        // Asynchronous reset before any clock edge
        #2 rst_n = 1'b0;
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_product", 32'(product), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_done", 32'(done), 32'd0);

        run_op(4'd13, 4'd11, "m13x11");
        tick();
        tick();
        check("m13x11_held", 32'(product), 32'h8F);
        run_op(4'd15, 4'd15, "m15x15");
        run_op(4'd0, 4'd9, "m0x9");
        run_op(4'd7, 4'd0, "m7x0");

        // Start while busy is ignored and new operands do not leak in
        a     = 4'd6;
        b     = 4'd5;
        start = 1'b1;
        dc0   = done_cnt;
        tick();
        start = 1'b0;
        check("sb_busy", 32'(busy), 32'd1);
        tick();
        start = 1'b1;
        a     = 4'd15;
        b     = 4'd15;
        tick();
        start = 1'b0;
        tick();
        tick();
        check("sb_done", 32'(done), 32'd1);
        check("sb_product", 32'(product), 32'h1E);
        repeat (8) tick();
        check("sb_one_done", 32'(done_cnt - dc0), 32'd1);
        check("sb_idle", 32'(busy), 32'd0);
        check("sb_hold", 32'(product), 32'h1E);

        // Reset mid-operation aborts with no done pulse
        a     = 4'd9;
        b     = 4'd9;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        dc0   = done_cnt;
        rst_n = 1'b0;
        #1;
        check("mr_busy", 32'(busy), 32'd0);
        check("mr_done", 32'(done), 32'd0);
        check("mr_product", 32'(product), 32'd0);
        tick();
        rst_n = 1'b1;
        repeat (6) tick();
        check("mr_no_done", 32'(done_cnt - dc0), 32'd0);
        check("mr_product_after", 32'(product), 32'd0);
        run_op(4'd2, 4'd3, "m2x3");

        // Back-to-back with start held high
        pa[0] = 4'd1;  pb[0] = 4'd1;
        pa[1] = 4'd12; pb[1] = 4'd10;
        pa[2] = 4'd15; pb[2] = 4'd1;
        for (int i = 0; i < 3; i++) pe[i] = int'(pa[i]) * int'(pb[i]);
        a        = pa[0];
        b        = pb[0];
        start    = 1'b1;
        seen     = 0;
        last_cyc = 0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            tick();
            if (done === 1'b1 && seen < 3) begin
                check("b2b_product", 32'(product), pe[seen]);
                if (seen > 0) check("b2b_spacing", 32'(cyc - last_cyc), 32'(W + 2));
                last_cyc = cyc;
                seen++;
                if (seen < 3) begin
                    a = pa[seen];
                    b = pb[seen];
                end else begin
                    start = 1'b0;
                end
            end
        end
        start = 1'b0;
        check("b2b_count", 32'(seen), 32'd3);

        // Random operands against plain multiplication
        for (int i = 0; i < 12; i++) begin
            run_op(W'($urandom_range(0, 15)), W'($urandom_range(0, 15)), "rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
